// File: rtl/fpu_pkg.sv
// Shared FPU register-file constants and the register-address type.
package fpu_pkg;

  localparam int FPU_WIDTH  = 32;
  localparam int FPU_ADDR_W = 4;
  localparam int FPU_NREGS  = 15;
  localparam logic [FPU_ADDR_W-1:0] FPU_EXT_ADDR = 4'hF;

  typedef logic [FPU_ADDR_W-1:0] fpu_raddr_t;

endpackage

// File: rtl/fpu_scoreboard.sv
// Pending-operation scoreboard: one reservation bit per physical FPU register,
// WAW issue gating, operand busy flags and a registered pending count.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int ADDR_W   = FPU_ADDR_W,
  parameter int NREGS    = FPU_NREGS,
  parameter int EXT_ADDR = 2**ADDR_W - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we3,
  input  logic [ADDR_W-1:0]          a3,
  input  logic                       issue,
  input  logic [ADDR_W-1:0]          issue_a,
  input  logic [ADDR_W-1:0]          ra1,
  input  logic [ADDR_W-1:0]          ra2,
  output logic                       issue_ok,
  output logic                       busy1,
  output logic                       busy2,
  output logic [$clog2(NREGS+1)-1:0] pend_cnt
);

  localparam int CNT_W = $clog2(NREGS+1);
  localparam logic [ADDR_W-1:0] EXT_A   = ADDR_W'(EXT_ADDR);
  localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W+1)'(NREGS);

  logic [NREGS-1:0] pending_r;
  logic [CNT_W-1:0] pend_cnt_r;
  logic [NREGS-1:0] set_vec_s;
  logic [NREGS-1:0] clr_vec_s;
  logic [NREGS-1:0] pend_next_s;
  logic             issue_ok_s;
  logic             busy1_s;
  logic             busy2_s;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_A) && (a != EXT_A);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Issue acceptance, busy flags and the next pending vector (set beats clear)
  always_comb begin
    issue_ok_s = 1'b0;
    busy1_s    = 1'b0;
    busy2_s    = 1'b0;
    set_vec_s  = '0;
    clr_vec_s  = '0;
    if (issue && addr_ok(issue_a)) begin
      issue_ok_s = !pending_r[issue_a] || (we3 && (a3 == issue_a));
    end else begin
      issue_ok_s = 1'b0;
    end
    if (addr_ok(ra1)) begin
      busy1_s = pending_r[ra1] && !(BYPASS && we3 && (a3 == ra1));
    end else begin
      busy1_s = 1'b0;
    end
    if (addr_ok(ra2)) begin
      busy2_s = pending_r[ra2] && !(BYPASS && we3 && (a3 == ra2));
    end else begin
      busy2_s = 1'b0;
    end
    if (issue_ok_s) begin
      set_vec_s[issue_a] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    if (we3 && addr_ok(a3)) begin
      clr_vec_s[a3] = 1'b1;
    end else begin
      clr_vec_s = '0;
    end
    pend_next_s = (pending_r & ~clr_vec_s) | set_vec_s;
  end

  // Pending bits and their count move together on each edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r  <= '0;
      pend_cnt_r <= '0;
    end else begin
      pending_r  <= pend_next_s;
      pend_cnt_r <= popcount(pend_next_s);
    end
  end

  assign issue_ok = issue_ok_s;
  assign busy1    = busy1_s;
  assign busy2    = busy2_s;
  assign pend_cnt = pend_cnt_r;

endmodule

// File: rtl/fpu_regfile_sb.sv
// FPU register file with two combinational read ports, one write port,
// optional write-to-read bypass, an external-register alias and a scoreboard.
module fpu_regfile_sb
  import fpu_pkg::*;
#(
  parameter int WIDTH    = FPU_WIDTH,
  parameter int ADDR_W   = FPU_ADDR_W,
  parameter int NREGS    = FPU_NREGS,
  parameter int EXT_ADDR = 2**ADDR_W - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we3,
  input  logic [ADDR_W-1:0]          a3,
  input  logic [WIDTH-1:0]           wd3,
  input  logic [ADDR_W-1:0]          ra1,
  input  logic [ADDR_W-1:0]          ra2,
  input  logic [WIDTH-1:0]           r15,
  output logic [WIDTH-1:0]           rd1,
  output logic [WIDTH-1:0]           rd2,
  input  logic                       issue,
  input  logic [ADDR_W-1:0]          issue_a,
  output logic                       issue_ok,
  output logic                       busy1,
  output logic                       busy2,
  output logic [$clog2(NREGS+1)-1:0] pend_cnt
);

  localparam logic [ADDR_W-1:0] EXT_A   = ADDR_W'(EXT_ADDR);
  localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W+1)'(NREGS);

  logic [WIDTH-1:0] rf_r [NREGS];
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_A) && (a != EXT_A);
  endfunction

  // Register storage; writes to the alias or unmapped addresses are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= '0;
      end
    end else if (we3 && addr_ok(a3)) begin
      rf_r[a3] <= wd3;
    end
  end

  // Read muxes: external alias, then unmapped, then bypass, then storage
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    if (ra1 == EXT_A) begin
      rd1_s = r15;
    end else if (!addr_ok(ra1)) begin
      rd1_s = '0;
    end else if (BYPASS && we3 && (a3 == ra1)) begin
      rd1_s = wd3;
    end else begin
      rd1_s = rf_r[ra1];
    end
    if (ra2 == EXT_A) begin
      rd2_s = r15;
    end else if (!addr_ok(ra2)) begin
      rd2_s = '0;
    end else if (BYPASS && we3 && (a3 == ra2)) begin
      rd2_s = wd3;
    end else begin
      rd2_s = rf_r[ra2];
    end
  end

  assign rd1 = rd1_s;
  assign rd2 = rd2_s;

  fpu_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NREGS   (NREGS),
    .EXT_ADDR(EXT_ADDR),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .we3     (we3),
    .a3      (a3),
    .issue   (issue),
    .issue_a (issue_a),
    .ra1     (ra1),
    .ra2     (ra2),
    .issue_ok(issue_ok),
    .busy1   (busy1),
    .busy2   (busy2),
    .pend_cnt(pend_cnt)
  );

endmodule

// File: tb/tb_fpu_regfile_sb.sv
// Self-checking bench for fpu_regfile_sb: vector table with an expectation
// queue, plus hand sequences for reset, no-bypass timing and a full scoreboard.
module tb_fpu_regfile_sb;
  import fpu_pkg::*;

  localparam int W  = FPU_WIDTH;
  localparam int CW = $clog2(FPU_NREGS + 1);
  localparam int NV = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          we3;
  fpu_raddr_t    a3;
  logic [W-1:0]  wd3;
  fpu_raddr_t    ra1;
  fpu_raddr_t    ra2;
  logic [W-1:0]  r15;
  logic          issue;
  fpu_raddr_t    issue_a;
  logic [W-1:0]  rd1, rd2, rd1_nb, rd2_nb;
  logic          issue_ok, busy1, busy2, issue_ok_nb, busy1_nb, busy2_nb;
  logic [CW-1:0] pend_cnt, pend_cnt_nb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] r15;
    logic        issue;
    logic [3:0]  issue_a;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_ok;
    logic        e_b1;
    logic        e_b2;
    logic [3:0]  e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        ok;
    logic        b1;
    logic        b2;
    logic [3:0]  cnt;
  } exp_t;

  vec_t vecs [NV];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  fpu_regfile_sb dut (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .r15(r15), .rd1(rd1), .rd2(rd2),
    .issue(issue), .issue_a(issue_a), .issue_ok(issue_ok),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  fpu_regfile_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .r15(r15), .rd1(rd1_nb), .rd2(rd2_nb),
    .issue(issue), .issue_a(issue_a), .issue_ok(issue_ok_nb),
    .busy1(busy1_nb), .busy2(busy2_nb), .pend_cnt(pend_cnt_nb)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    we3 = 1'b0; a3 = 4'd0; wd3 = 32'h0; ra1 = 4'd0; ra2 = 4'd0;
    r15 = 32'h0; issue = 1'b0; issue_a = 4'd0;
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [3:0] a,
                              input logic [31:0] d, input logic [3:0] r1, input logic [3:0] r2,
                              input logic [31:0] x, input logic is, input logic [3:0] ia,
                              input logic [31:0] e1, input logic [31:0] e2, input logic ok,
                              input logic b1, input logic b2, input logic [3:0] c);
    vec_t v;
    v.name = n; v.we3 = w; v.a3 = a; v.wd3 = d; v.ra1 = r1; v.ra2 = r2; v.r15 = x;
    v.issue = is; v.issue_a = ia; v.e_rd1 = e1; v.e_rd2 = e2; v.e_ok = ok;
    v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = c;
    return v;
  endfunction

  initial begin
    logic [31:0] saved3;
    exp_t        e;
    saved3 = 32'h0;

    //              name         we a     wd3           ra1    ra2    r15           is ia     e_rd1         e_rd2         ok    b1    b2    cnt
    vecs[0]  = mk("rst_rd",     1'b0, 4'd0, 32'h0,        4'd3,  4'd14, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'd0);
    vecs[1]  = mk("ext_rd",     1'b0, 4'd0, 32'h0,        4'd15, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0);
    vecs[2]  = mk("bypass",     1'b1, 4'd5, 32'h3F800000, 4'd5,  4'd4,  32'h0,        1'b0, 4'd0, 32'h3F800000, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0);
    vecs[3]  = mk("stored",     1'b0, 4'd0, 32'h0,        4'd5,  4'd5,  32'h0,        1'b0, 4'd0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 4'd0);
    vecs[4]  = mk("ext_wr",     1'b1, 4'd15,32'h12345678, 4'd15, 4'd5,  32'hCAFEF00D, 1'b0, 4'd0, 32'hCAFEF00D, 32'h3F800000, 1'b0, 1'b0, 1'b0, 4'd0);
    vecs[5]  = mk("ext_after",  1'b0, 4'd0, 32'h0,        4'd15, 4'd5,  32'h0,        1'b0, 4'd0, 32'h0,        32'h3F800000, 1'b0, 1'b0, 1'b0, 4'd0);
    vecs[6]  = mk("issue7",     1'b0, 4'd0, 32'h0,        4'd7,  4'd0,  32'h0,        1'b1, 4'd7, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 4'd0);
    vecs[7]  = mk("busy7",      1'b0, 4'd0, 32'h0,        4'd7,  4'd7,  32'h0,        1'b1, 4'd7, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 4'd1);
    vecs[8]  = mk("wb7",        1'b1, 4'd7, 32'h40490FDB, 4'd7,  4'd6,  32'h0,        1'b0, 4'd0, 32'h40490FDB, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1);
    vecs[9]  = mk("freed7",     1'b0, 4'd0, 32'h0,        4'd7,  4'd0,  32'h0,        1'b0, 4'd0, 32'h40490FDB, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0);
    vecs[10] = mk("issue2",     1'b0, 4'd0, 32'h0,        4'd0,  4'd0,  32'h0,        1'b1, 4'd2, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 4'd0);
    vecs[11] = mk("set_clr2",   1'b1, 4'd2, 32'h11111111, 4'd2,  4'd0,  32'h0,        1'b1, 4'd2, 32'h11111111, 32'h0,        1'b1, 1'b0, 1'b0, 4'd1);
    vecs[12] = mk("still2",     1'b0, 4'd0, 32'h0,        4'd2,  4'd2,  32'h0,        1'b1, 4'd2, 32'h11111111, 32'h11111111, 1'b0, 1'b1, 1'b1, 4'd1);
    vecs[13] = mk("inv_issue",  1'b0, 4'd0, 32'h0,        4'd2,  4'd15, 32'h0,        1'b1, 4'd15,32'h11111111, 32'h0,        1'b0, 1'b1, 1'b0, 4'd1);
    vecs[14] = mk("wb_nonpend", 1'b1, 4'd9, 32'hABCDEF01, 4'd9,  4'd2,  32'h0,        1'b0, 4'd0, 32'hABCDEF01, 32'h11111111, 1'b0, 1'b0, 1'b1, 4'd1);
    vecs[15] = mk("after_np",   1'b0, 4'd0, 32'h0,        4'd9,  4'd2,  32'h0,        1'b0, 4'd0, 32'hABCDEF01, 32'h11111111, 1'b0, 1'b0, 1'b1, 4'd1);
    vecs[16] = mk("wb2",        1'b1, 4'd2, 32'h22222222, 4'd0,  4'd2,  32'h0,        1'b0, 4'd0, 32'h0,        32'h22222222, 1'b0, 1'b0, 1'b0, 4'd1);
    vecs[17] = mk("empty",      1'b0, 4'd0, 32'h0,        4'd2,  4'd0,  32'h0,        1'b0, 4'd0, 32'h22222222, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0);

    // Initial reset, then dirty every register and reservation
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      we3 = 1'b1; a3 = 4'(i); wd3 = $urandom; issue = 1'b1; issue_a = 4'(i);
      if (i == 3) saved3 = wd3;
    end
    @(negedge clk);
    idle();
    ra1 = 4'd3;
    #1;
    check("dirty.rd1", rd1, saved3);
    check("dirty.cnt", 32'(pend_cnt), 32'd15);

    // Reset held two cycles while writes and issues are presented
    @(negedge clk);
    reset = 1'b0; we3 = 1'b1; a3 = 4'd1; wd3 = 32'hFFFF; issue = 1'b1; issue_a = 4'd3;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
    ra1 = 4'd3; ra2 = 4'd1;
    #1;
    check("rst.rd1", rd1, 32'h0);
    check("rst.rd2", rd2, 32'h0);
    check("rst.busy1", 32'(busy1), 32'd0);
    check("rst.cnt", 32'(pend_cnt), 32'd0);

    // Table vectors through the expectation queue
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; r15 = vecs[i].r15;
      issue = vecs[i].issue; issue_a = vecs[i].issue_a;
      exp_q.push_back('{vecs[i].name, vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_ok,
                        vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_cnt});
      #1;
      e = exp_q.pop_front();
      check({e.name, ".rd1"}, rd1, e.rd1);
      check({e.name, ".rd2"}, rd2, e.rd2);
      check({e.name, ".ok"}, 32'(issue_ok), 32'(e.ok));
      check({e.name, ".busy1"}, 32'(busy1), 32'(e.b1));
      check({e.name, ".busy2"}, 32'(busy2), 32'(e.b2));
      check({e.name, ".cnt"}, 32'(pend_cnt), 32'(e.cnt));
    end

    // No-bypass instance: old value / still busy until the next cycle
    @(negedge clk);
    idle();
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'h40000000; ra1 = 4'd5;
    #1;
    check("bp1.rd1", rd1, 32'h40000000);
    check("nb.rd1_old", rd1_nb, 32'h3F800000);
    @(negedge clk);
    idle();
    ra1 = 4'd5;
    #1;
    check("nb.rd1_new", rd1_nb, 32'h40000000);
    @(negedge clk);
    issue = 1'b1; issue_a = 4'd8;
    #1;
    check("nb.issue8", 32'(issue_ok_nb), 32'd1);
    @(negedge clk);
    idle();
    we3 = 1'b1; a3 = 4'd8; wd3 = 32'h5; ra1 = 4'd8;
    #1;
    check("bp1.busy_wb", 32'(busy1), 32'd0);
    check("nb.busy_wb", 32'(busy1_nb), 32'd1);
    check("nb.rd1_wb", rd1_nb, 32'h0);
    check("nb.cnt_wb", 32'(pend_cnt_nb), 32'd1);
    @(negedge clk);
    idle();
    ra1 = 4'd8;
    #1;
    check("nb.busy_free", 32'(busy1_nb), 32'd0);
    check("nb.rd1_free", rd1_nb, 32'h5);
    check("cnt_free", 32'(pend_cnt), 32'd0);

    // Fill every register back-to-back
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle();
      issue = 1'b1; issue_a = 4'(i);
      #1;
      check($sformatf("fill%0d.ok", i), 32'(issue_ok), 32'd1);
      check($sformatf("fill%0d.cnt", i), 32'(pend_cnt), 32'(i));
    end
    @(negedge clk);
    idle();
    issue = 1'b1; issue_a = 4'd3; ra1 = 4'd4; ra2 = 4'd14;
    #1;
    check("full.ok", 32'(issue_ok), 32'd0);
    check("full.cnt", 32'(pend_cnt), 32'd15);
    check("full.busy1", 32'(busy1), 32'd1);
    check("full.busy2", 32'(busy2), 32'd1);

    // Reset in the middle of outstanding work
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    issue = 1'b1; issue_a = 4'd3; ra1 = 4'd4; ra2 = 4'd5;
    #1;
    check("mid_rst.cnt", 32'(pend_cnt), 32'd0);
    check("mid_rst.busy1", 32'(busy1), 32'd0);
    check("mid_rst.busy1_nb", 32'(busy1_nb), 32'd0);
    check("mid_rst.rd2", rd2, 32'h0);
    check("mid_rst.ok", 32'(issue_ok), 32'd1);

    @(negedge clk);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_regfile_sb.md
Name: fpu_regfile_sb

Overview:
Parametrised successor to the FPU register file, with two combinational read ports and one write port. It adds a per-register pending scoreboard for multi-cycle FPU operations, optional same-cycle write-to-read bypass, a configurable external-register alias, and synchronous clear on reset. It sits between FPU decode/issue, which reads operands and reserves destinations, and the FPU writeback stage, which writes results and releases reservations.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 4, register address width
NREGS, 15, number of physical registers; must satisfy 1 <= NREGS <= 2**ADDR_W - 1
EXT_ADDR, 2**ADDR_W-1, address aliased to the external input r15 (never a physical register)
BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
we3  in  1  writeback enable
a3  in  ADDR_W  writeback address
wd3  in  WIDTH  writeback data
ra1  in  ADDR_W  read address port 1
ra2  in  ADDR_W  read address port 2
r15  in  WIDTH  external value returned for EXT_ADDR
rd1  out  WIDTH  read data port 1
rd2  out  WIDTH  read data port 2
issue  in  1  request to reserve destination issue_a
issue_a  in  ADDR_W  destination being reserved
issue_ok  out  1  reservation accepted this cycle
busy1  out  1  ra1 operand not yet available
busy2  out  1  ra2 operand not yet available
pend_cnt  out  $clog2(NREGS+1)  number of registers currently pending

Behaviour:
- Reset: clk and reset are named as in the rest of the codebase. The reset is synchronous and active-low. At a rising edge with reset=0, all rf entries clear to 0 and all pending bits clear. Writes and issues in that cycle are ignored. After reset, rd1/rd2 = 0 (for physical addresses), busy1/busy2 = 0, pend_cnt = 0, and issue_ok = issue for any valid address.
- Valid physical address: addr < NREGS and addr != EXT_ADDR.
- Write: at the edge with reset=1, we3=1 and a3 valid, rf[a3] <= wd3. Writes to invalid addresses (including EXT_ADDR) are dropped silently.
- Read (combinational, zero latency), priority order:
  1. ra == EXT_ADDR -> r15.
  2. Invalid address -> 0.
  3. BYPASS=1, we3=1, a3==ra -> wd3.
  4. Otherwise -> rf[ra].
  rd1 and rd2 are evaluated independently; both may hit the same register or the bypass.
- Scoreboard: one pending bit per physical register.
  - Set: at the edge where issue_ok=1.
  - Clear: at the edge where we3=1 with a valid a3.
  - Same register set and cleared in the same cycle: set wins; the new operation stays outstanding.
  - Writeback to a non-pending register: writes data; pending stays 0.
- issue_ok = issue AND issue_a valid AND (pending[issue_a]==0 OR (we3 AND a3==issue_a)). This refuses a WAW on an outstanding register unless it retires this cycle. A refused issue leaves no state change; the requester holds and retries.
- busyN = pending[raN] AND raN valid AND NOT (BYPASS AND we3 AND a3==raN). EXT_ADDR and invalid addresses are never busy. With BYPASS=0, a register retiring this cycle is still busy; it frees on the next cycle.
- pend_cnt: registered popcount of the pending bits. Updates on the same edge as the bits: +1 on set only, -1 on clear only, unchanged on set and clear of the same register. Range 0..NREGS, no wrap.
- Latency: write to read is 0 cycles with BYPASS=1, else 1 cycle. Issue to busy is 1 cycle.

Decomposition:
- Shared package fpu_pkg: FPU_WIDTH=32, FPU_ADDR_W=4, FPU_NREGS=15, FPU_EXT_ADDR=4'hF, and the register-address typedef fpu_raddr_t.
- One sub-module, fpu_scoreboard. It holds the pending bits, pend_cnt, issue_ok and the busy logic.
- The top level holds the rf array, read muxes and bypass.

Test Plan:
1. Reset low for 2 cycles after random writes -> rf all 0, pend_cnt=0, busy1=busy2=0. ra1=3 reads 0.
2. we3=1, a3=5, wd3=0x3F800000 with ra1=5 -> rd1=0x3F800000 in the same cycle (BYPASS=1). With BYPASS=0, rd1 is the old value, then 0x3F800000 on the next cycle.
3. ra1=15, r15=0xDEADBEEF -> rd1=0xDEADBEEF. A write to a3=15 leaves rf unchanged and pend_cnt unchanged.
4. issue=1, issue_a=7 -> issue_ok=1. Next cycle busy1=1 for ra1=7 and pend_cnt=1. A second issue to 7 -> issue_ok=0. Writeback to 7 -> busy1=0 in the same cycle (BYPASS=1), pend_cnt=0 on the next cycle.
5. Register 2 pending. Same cycle: issue_a=2 with we3=1, a3=2 -> issue_ok=1. After the edge, pending[2]=1 and pend_cnt unchanged at 1.
6. Issue registers 0..14 back-to-back -> pend_cnt=15. A further issue is refused. Reset asserted mid-sequence -> pend_cnt=0 and all busy outputs clear on the next cycle.
